// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// Data-hazard unit for a 5-stage MIPS-style pipeline. It tracks the
// destination register of the instructions in EX, MEM and WB. From those
// entries it does three things:
//   - It detects a load-use hazard against the decode-stage instruction.
//     On a hazard it stalls decode and inserts a bubble into EX.
//   - It produces registered EX-stage operand forwarding selects.
//   - It counts load-use stall cycles in a saturating performance counter.
//
// Ports
//   i_clk            clock, all state updates on the rising edge
//   i_rst_n          asynchronous active-low reset
//   i_instr_valid    decode-stage instruction valid
//   i_rs, i_rt       decode-stage source register fields
//   i_re_rs, i_re_rt source read enables
//   i_wa, i_we       decode-stage destination register and write enable
//   i_is_load        decode-stage instruction is a load (LW)
//   i_flush          kill the decode-stage instruction (taken branch/jump)
//   i_ext_stall      memory wait, freezes the whole pipeline
//   o_stall          hold PC and IF/ID (combinational)
//   o_fwd_rs/o_fwd_rt EX operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   o_stall_cnt      saturating count of load-use stall cycles
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_instr_valid,
    input  logic [4:0]       i_rs,
    input  logic [4:0]       i_rt,
    input  logic             i_re_rs,
    input  logic             i_re_rt,
    input  logic [4:0]       i_wa,
    input  logic             i_we,
    input  logic             i_is_load,
    input  logic             i_flush,
    input  logic             i_ext_stall,
    output logic             o_stall,
    output logic [1:0]       o_fwd_rs,
    output logic [1:0]       o_fwd_rt,
    output logic [CNT_W-1:0] o_stall_cnt
);

    typedef struct packed {
        logic       valid;
        logic [4:0] wa;
        logic       we;
        logic       is_load;
    } entry_t;

    entry_t ex_q;
    entry_t mem_q;
    entry_t wb_q;
    entry_t ex_d;

    logic rs_hit_ex;
    logic rs_hit_mem;
    logic rs_hit_wb;
    logic rt_hit_ex;
    logic rt_hit_mem;
    logic rt_hit_wb;
    logic load_use;
    logic issue;

    // Register 0 is hardwired to zero, so it can never be a real producer.
    function automatic logic writes_reg(input entry_t e, input logic [4:0] r);
        return e.valid && e.we && (e.wa == r) && (r != 5'd0);
    endfunction

    // The youngest producer wins. A WB producer selects the register file,
    // exactly as if there were no hit: the register file writes before it
    // reads, so decode already sees that value.
    function automatic logic [1:0] fwd_sel(input logic hit_ex,
                                           input logic hit_mem,
                                           input logic hit_wb);
        logic [1:0] sel;
        if (hit_ex)
            sel = 2'b01;
        else if (hit_mem)
            sel = 2'b10;
        else if (hit_wb)
            sel = 2'b00;
        else
            sel = 2'b00;
        return sel;
    endfunction

    // Hazard detection against the decode-stage operands.
    // A flushed instruction never stalls; it simply becomes a bubble.
    always_comb begin
        rs_hit_ex  = i_re_rs && writes_reg(ex_q,  i_rs);
        rs_hit_mem = i_re_rs && writes_reg(mem_q, i_rs);
        rs_hit_wb  = i_re_rs && writes_reg(wb_q,  i_rs);
        rt_hit_ex  = i_re_rt && writes_reg(ex_q,  i_rt);
        rt_hit_mem = i_re_rt && writes_reg(mem_q, i_rt);
        rt_hit_wb  = i_re_rt && writes_reg(wb_q,  i_rt);
        load_use   = i_instr_valid && !i_flush && ex_q.is_load
                     && (rs_hit_ex || rt_hit_ex);
        issue      = i_instr_valid && !i_flush && !load_use;
        o_stall    = i_ext_stall || load_use;
        ex_d       = {issue, i_wa, i_we, i_is_load};
    end

    // Pipeline advance of the scoreboard, forwarding selects and counter.
    // The whole block freezes while memory holds the pipeline.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            o_fwd_rs    <= 2'b00;
            o_fwd_rt    <= 2'b00;
            o_stall_cnt <= '0;
        end else if (!i_ext_stall) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= ex_d;
            if (issue) begin
                o_fwd_rs <= fwd_sel(rs_hit_ex, rs_hit_mem, rs_hit_wb);
                o_fwd_rt <= fwd_sel(rt_hit_ex, rt_hit_mem, rt_hit_wb);
            end else begin
                o_fwd_rs <= 2'b00;
                o_fwd_rt <= 2'b00;
            end
            if (load_use && (o_stall_cnt != '1))
                o_stall_cnt <= o_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Scoreboard bench for hazard_scoreboard.
//
// The stimulus process drives one decode-stage instruction per cycle. It
// pushes the expected outputs for that cycle into exp_q. The expectation
// comes from a reference model: a history of issued slots, youngest first,
// and a producer-distance search. A monitor pops exp_q on every falling edge
// and compares. Directed scenarios also check a few hand-derived constants.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             instr_valid;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic             re_rs;
    logic             re_rt;
    logic [4:0]       wa;
    logic             we;
    logic             is_load;
    logic             flush;
    logic             ext_stall;
    logic             stall;
    logic [1:0]       fwd_rs;
    logic [1:0]       fwd_rt;
    logic [CNT_W-1:0] stall_cnt;

    hazard_scoreboard #(.CNT_W(CNT_W)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_instr_valid (instr_valid),
        .i_rs          (rs),
        .i_rt          (rt),
        .i_re_rs       (re_rs),
        .i_re_rt       (re_rt),
        .i_wa          (wa),
        .i_we          (we),
        .i_is_load     (is_load),
        .i_flush       (flush),
        .i_ext_stall   (ext_stall),
        .o_stall       (stall),
        .o_fwd_rs      (fwd_rs),
        .o_fwd_rt      (fwd_rt),
        .o_stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       valid;
        bit [4:0] rs;
        bit [4:0] rt;
        bit       re_rs;
        bit       re_rt;
        bit [4:0] wa;
        bit       we;
        bit       ld;
    } instr_t;

    typedef struct {
        bit       v;
        bit [4:0] wa;
        bit       we;
        bit       ld;
    } slot_t;

    typedef struct {
        bit stall;
        int fwd_rs;
        int fwd_rt;
        int cnt;
    } exp_t;

    exp_t  exp_q[$];
    slot_t hist[$];
    int    m_fwd_rs;
    int    m_fwd_rt;
    int    m_cnt;
    bit    m_last_stall;
    int    check_cnt = 0;
    int    error_cnt = 0;

    function automatic instr_t alu(input int rd, input int s, input int t);
        instr_t i;
        i.valid = 1'b1; i.rs = 5'(s); i.rt = 5'(t);
        i.re_rs = 1'b1; i.re_rt = 1'b1;
        i.wa = 5'(rd); i.we = 1'b1; i.ld = 1'b0;
        return i;
    endfunction

    function automatic instr_t lw(input int rd, input int base);
        instr_t i;
        i.valid = 1'b1; i.rs = 5'(base); i.rt = 5'(rd);
        i.re_rs = 1'b1; i.re_rt = 1'b0;
        i.wa = 5'(rd); i.we = 1'b1; i.ld = 1'b1;
        return i;
    endfunction

    function automatic instr_t nop();
        instr_t i;
        i.valid = 1'b1; i.rs = 5'd0; i.rt = 5'd0;
        i.re_rs = 1'b0; i.re_rt = 1'b0;
        i.wa = 5'd0; i.we = 1'b0; i.ld = 1'b0;
        return i;
    endfunction

    function automatic instr_t bubble();
        instr_t i;
        i = nop();
        i.valid = 1'b0;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        int kind;
        kind = int'($urandom_range(0, 3));
        if (kind == 0)
            i = lw(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        else if (kind == 3)
            i = nop();
        else begin
            i = alu(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 7)));
            i.re_rt = ($urandom_range(0, 4) != 0);
            i.we    = ($urandom_range(0, 6) != 0);
        end
        if ($urandom_range(0, 9) == 0)
            i.valid = 1'b0;
        return i;
    endfunction

    // Distance (0 = EX, 1 = MEM) to the youngest in-flight writer of r.
    // Returns -1 when nothing forwardable writes r.
    function automatic int producer_age(input bit re, input bit [4:0] r);
        if (!re || r == 5'd0)
            return -1;
        for (int a = 0; a < 2; a++)
            if (hist[a].v && hist[a].we && hist[a].wa == r)
                return a;
        return -1;
    endfunction

    function automatic int age_to_sel(input int age);
        return (age == 0) ? 1 : ((age == 1) ? 2 : 0);
    endfunction

    task automatic model_reset();
        slot_t s;
        s.v = 1'b0; s.wa = 5'd0; s.we = 1'b0; s.ld = 1'b0;
        hist.delete();
        repeat (3) hist.push_back(s);
        m_fwd_rs = 0;
        m_fwd_rt = 0;
        m_cnt    = 0;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        check_cnt++;
        if (actual != expected) begin
            error_cnt++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic setInputs(input instr_t in, input bit fl, input bit ext);
        instr_valid = in.valid;
        rs          = in.rs;
        rt          = in.rt;
        re_rs       = in.re_rs;
        re_rt       = in.re_rt;
        wa          = in.wa;
        we          = in.we;
        is_load     = in.ld;
        flush       = fl;
        ext_stall   = ext;
    endtask

    // Predict this cycle's outputs, queue them, then advance the model
    // across the rising edge.
    task automatic stepCycle(input instr_t in, input bit fl, input bit ext);
        int    ars;
        int    art;
        bit    lu;
        bit    iss;
        exp_t  e;
        slot_t s;
        ars = producer_age(in.re_rs, in.rs);
        art = producer_age(in.re_rt, in.rt);
        lu  = in.valid && !fl && hist[0].ld && (ars == 0 || art == 0);
        iss = in.valid && !fl && !lu;
        e.stall  = ext || lu;
        e.fwd_rs = m_fwd_rs;
        e.fwd_rt = m_fwd_rt;
        e.cnt    = m_cnt;
        exp_q.push_back(e);
        m_last_stall = lu;
        @(posedge clk);
        if (rst_n && !ext) begin
            s.v = iss; s.wa = in.wa; s.we = in.we; s.ld = in.ld;
            hist.push_front(s);
            void'(hist.pop_back());
            m_fwd_rs = iss ? age_to_sel(ars) : 0;
            m_fwd_rt = iss ? age_to_sel(art) : 0;
            if (lu && m_cnt < CNT_MAX)
                m_cnt++;
        end
        #1;
    endtask

    task automatic applyStimulus(input instr_t in, input bit fl = 1'b0, input bit ext = 1'b0);
        setInputs(in, fl, ext);
        stepCycle(in, fl, ext);
    endtask

    task automatic bubbles();
        repeat (3) applyStimulus(bubble());
    endtask

    // Monitor: compares the DUT against the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("sb_stall",     int'(stall),     int'(e.stall));
                checkOutput("sb_fwd_rs",    int'(fwd_rs),    e.fwd_rs);
                checkOutput("sb_fwd_rt",    int'(fwd_rt),    e.fwd_rt);
                checkOutput("sb_stall_cnt", int'(stall_cnt), e.cnt);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        instr_t cur;
        bit     fl;
        bit     ext;
        int     w;

        setInputs(bubble(), 1'b0, 1'b0);
        model_reset();
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(bubble(), 1'b0, 1'b1);
        checkOutput("reset_cnt", int'(stall_cnt), 0);
        rst_n = 1'b1;
        bubbles();

        // ADD r3 then ADD r4,r3,r5: EX forward, no stall.
        applyStimulus(alu(3, 1, 2));
        setInputs(alu(4, 3, 5), 1'b0, 1'b0);
        #1 checkOutput("raw_ex_stall", int'(stall), 0);
        stepCycle(alu(4, 3, 5), 1'b0, 1'b0);
        checkOutput("raw_ex_fwd_rs", int'(fwd_rs), 1);
        checkOutput("raw_ex_fwd_rt", int'(fwd_rt), 0);

        // ADD r3, NOP, SUB r6,r1,r3: MEM forward on rt.
        bubbles();
        applyStimulus(alu(3, 1, 2));
        applyStimulus(nop());
        applyStimulus(alu(6, 1, 3));
        checkOutput("raw_mem_fwd_rt", int'(fwd_rt), 2);
        checkOutput("raw_mem_fwd_rs", int'(fwd_rs), 0);

        // LW r2 then AND r7,r2,r2: one stall cycle, then MEM forward.
        bubbles();
        applyStimulus(lw(2, 1));
        setInputs(alu(7, 2, 2), 1'b0, 1'b0);
        #1 checkOutput("lu_stall", int'(stall), 1);
        stepCycle(alu(7, 2, 2), 1'b0, 1'b0);
        checkOutput("lu_bubble_fwd_rs", int'(fwd_rs), 0);
        checkOutput("lu_cnt", int'(stall_cnt), 1);
        setInputs(alu(7, 2, 2), 1'b0, 1'b0);
        #1 checkOutput("lu_release", int'(stall), 0);
        stepCycle(alu(7, 2, 2), 1'b0, 1'b0);
        checkOutput("lu_fwd_rs", int'(fwd_rs), 2);
        checkOutput("lu_fwd_rt", int'(fwd_rt), 2);

        // LW r0 then OR r1,r0,r0: register 0 never matches.
        bubbles();
        applyStimulus(lw(0, 1));
        setInputs(alu(1, 0, 0), 1'b0, 1'b0);
        #1 checkOutput("r0_stall", int'(stall), 0);
        stepCycle(alu(1, 0, 0), 1'b0, 1'b0);
        checkOutput("r0_fwd_rs", int'(fwd_rs), 0);
        checkOutput("r0_fwd_rt", int'(fwd_rt), 0);

        // Flush beats load-use; then an external stall holds everything.
        bubbles();
        applyStimulus(lw(2, 1));
        setInputs(alu(7, 2, 2), 1'b1, 1'b0);
        #1 checkOutput("flush_stall", int'(stall), 0);
        stepCycle(alu(7, 2, 2), 1'b1, 1'b0);
        checkOutput("flush_cnt", int'(stall_cnt), 1);
        applyStimulus(alu(4, 2, 2));
        checkOutput("flush_next_fwd_rs", int'(fwd_rs), 2);
        for (int k = 0; k < 3; k++) begin
            setInputs(alu(5, 4, 4), 1'b0, 1'b1);
            #1 checkOutput("ext_stall", int'(stall), 1);
            stepCycle(alu(5, 4, 4), 1'b0, 1'b1);
            checkOutput("ext_hold_fwd_rs", int'(fwd_rs), 2);
            checkOutput("ext_hold_fwd_rt", int'(fwd_rt), 2);
        end
        applyStimulus(alu(5, 4, 4));
        checkOutput("ext_release_fwd_rs", int'(fwd_rs), 1);

        // Randomized traffic; decode holds its instruction while stalled.
        cur = rand_instr();
        repeat (600) begin
            ext = ($urandom_range(0, 7) == 0);
            fl  = !ext && ($urandom_range(0, 9) == 0);
            applyStimulus(cur, fl, ext);
            if (fl || !(ext || m_last_stall))
                cur = rand_instr();
        end

        // Drive the counter into saturation, then one more stall.
        bubbles();
        repeat (CNT_MAX + 2) begin
            applyStimulus(lw(2, 1));
            applyStimulus(alu(7, 2, 2));
            applyStimulus(alu(7, 2, 2));
        end
        checkOutput("cnt_saturated", int'(stall_cnt), CNT_MAX);
        applyStimulus(lw(2, 1));
        setInputs(alu(7, 2, 2), 1'b0, 1'b0);
        #1 checkOutput("sat_stall", int'(stall), 1);
        stepCycle(alu(7, 2, 2), 1'b0, 1'b0);
        checkOutput("cnt_stays_max", int'(stall_cnt), CNT_MAX);

        // Async reset mid-cycle while a load-use stall is pending.
        applyStimulus(alu(7, 2, 2));
        applyStimulus(lw(2, 1));
        setInputs(alu(7, 2, 2), 1'b0, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_cnt", int'(stall_cnt), 0);
        checkOutput("async_rst_fwd_rs", int'(fwd_rs), 0);
        checkOutput("async_rst_fwd_rt", int'(fwd_rt), 0);
        checkOutput("async_rst_stall", int'(stall), 0);
        model_reset();
        @(posedge clk);
        #1;
        applyStimulus(alu(7, 2, 2), 1'b0, 1'b1);
        rst_n = 1'b1;
        applyStimulus(alu(7, 2, 2));
        checkOutput("post_rst_fwd_rs", int'(fwd_rs), 0);

        cur = rand_instr();
        repeat (200) begin
            ext = ($urandom_range(0, 7) == 0);
            fl  = !ext && ($urandom_range(0, 9) == 0);
            applyStimulus(cur, fl, ext);
            if (fl || !(ext || m_last_stall))
                cur = rand_instr();
        end

        w = 0;
        while (exp_q.size() > 0 && w < 10) begin
            @(posedge clk);
            w++;
        end
        if (exp_q.size() > 0)
            checkOutput("drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
        $finish;
    end

endmodule
